// File: rtl/prog_loader_if.sv
// prog_loader_if: groups the start/stream/memory/cpu-control signals of the
// program loader. master = loader side, slave = environment (cpu memories,
// stream source and dump consumer).
interface prog_loader_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [31:0]       addr_ext;
  logic              wen_ext;
  logic [DATA_W-1:0] wdata_ext;
  logic [31:0]       addr_ext_2;
  logic              wen_ext_2;
  logic              ren_ext_2;
  logic [DATA_W-1:0] wdata_ext_2;
  logic [DATA_W-1:0] rdata_ext_2;
  logic              cpu_enable;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, in_valid, in_data, rdata_ext_2, out_ready,
    output in_ready, addr_ext, wen_ext, wdata_ext, addr_ext_2, wen_ext_2,
           ren_ext_2, wdata_ext_2, cpu_enable, out_valid, out_data,
           busy, done, err
  );

  modport slave (
    output start, in_valid, in_data, rdata_ext_2, out_ready,
    input  in_ready, addr_ext, wen_ext, wdata_ext, addr_ext_2, wen_ext_2,
           ren_ext_2, wdata_ext_2, cpu_enable, out_valid, out_data,
           busy, done, err
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: boot/test sequencer in front of the cpu. Loads a program image
// from a word stream into imem/dmem, enables the cpu for a programmed number
// of cycles, then dumps dmem back out on the output stream.
// Optional build macro PROG_LOADER_CHECKSUM_EN: a trailer word after the image
// must equal the modulo-2^32 sum of all loaded words, otherwise err and abort.
//
// state   | meaning
// IDLE    | waiting for start
// HDR0    | accept {imem_cnt, dmem_cnt}
// HDR1    | accept run_cycles
// LD_IMEM | stream words into imem
// LD_DMEM | stream words into dmem
// CHK     | accept checksum trailer (checksum build only)
// RUN     | cpu_enable high, run counter counting down
// DUMP    | read dmem word by word and present it on the output stream
module prog_loader #(
  parameter int DATA_W     = 32,
  parameter int IMEM_DEPTH = 512,
  parameter int DMEM_DEPTH = 1024,
  parameter int ADDR_STEP  = 4
) (
  input logic            clk,
  input logic            arst_n,
  prog_loader_if.master  bus
);
  typedef enum logic [2:0] {
    IDLE, HDR0, HDR1, LD_IMEM, LD_DMEM, CHK, RUN, DUMP
  } state_t;

  state_t      state, nxt, load_end;
  logic [15:0] imem_cnt, dmem_cnt, idx;
  logic [31:0] run_cnt;
  logic [31:0] idx_addr;
  logic        rd_pend;
  logic        in_hs, out_hs, hdr_bad;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0] sum;
`endif

  function automatic state_t after_run(input logic [15:0] dcnt);
    return (dcnt != 16'd0) ? DUMP : IDLE;
  endfunction

  function automatic state_t exec_state(input logic [31:0] run, input logic [15:0] dcnt);
    return (run != 32'd0) ? RUN : after_run(dcnt);
  endfunction

  assign in_hs    = bus.in_valid && bus.in_ready;
  assign out_hs   = bus.out_valid && bus.out_ready;
  assign idx_addr = 32'(idx) * 32'(ADDR_STEP);
  assign hdr_bad  = ({16'd0, bus.in_data[31:16]} > 32'(IMEM_DEPTH)) ||
                    ({16'd0, bus.in_data[15:0]} > 32'(DMEM_DEPTH));

  // Stream-side and memory-side strobes decoded from state and handshake.
  always_comb begin
    bus.in_ready = (state == HDR0) || (state == HDR1) ||
                   (state == LD_IMEM) || (state == LD_DMEM);
`ifdef PROG_LOADER_CHECKSUM_EN
    if (state == CHK) bus.in_ready = 1'b1;
`endif
    bus.wen_ext     = (state == LD_IMEM) && in_hs;
    bus.addr_ext    = bus.wen_ext ? idx_addr : 32'd0;
    bus.wdata_ext   = bus.wen_ext ? bus.in_data : '0;
    bus.wen_ext_2   = (state == LD_DMEM) && in_hs;
    // one read outstanding at most: wait for the held word to be taken
    bus.ren_ext_2   = (state == DUMP) && !rd_pend && !bus.out_valid;
    bus.addr_ext_2  = (bus.wen_ext_2 || bus.ren_ext_2) ? idx_addr : 32'd0;
    bus.wdata_ext_2 = bus.wen_ext_2 ? bus.in_data : '0;
    bus.cpu_enable  = (state == RUN);
    bus.busy        = (state != IDLE);
  end

  // Next-state decode; load_end is where the image load finishes.
  always_comb begin
`ifdef PROG_LOADER_CHECKSUM_EN
    load_end = CHK;
`else
    load_end = exec_state(run_cnt, dmem_cnt);
`endif
    nxt = state;
    case (state)
      IDLE:    if (bus.start) nxt = HDR0;
      HDR0:    if (in_hs) nxt = hdr_bad ? IDLE : HDR1;
      HDR1: begin
        if (in_hs) begin
          if (imem_cnt != 16'd0)      nxt = LD_IMEM;
          else if (dmem_cnt != 16'd0) nxt = LD_DMEM;
          else begin
`ifdef PROG_LOADER_CHECKSUM_EN
            nxt = CHK;
`else
            nxt = exec_state(bus.in_data[31:0], dmem_cnt);
`endif
          end
        end
      end
      LD_IMEM: if (in_hs && idx == imem_cnt - 16'd1)
                 nxt = (dmem_cnt != 16'd0) ? LD_DMEM : load_end;
      LD_DMEM: if (in_hs && idx == dmem_cnt - 16'd1) nxt = load_end;
      CHK: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        if (in_hs) nxt = (bus.in_data[31:0] == sum) ? exec_state(run_cnt, dmem_cnt) : IDLE;
`else
        nxt = IDLE;
`endif
      end
      RUN:     if (run_cnt == 32'd1) nxt = after_run(dmem_cnt);
      DUMP:    if (out_hs && idx == dmem_cnt - 16'd1) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Sequencer state, counters and registered status/dump outputs.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state         <= IDLE;
      imem_cnt      <= '0;
      dmem_cnt      <= '0;
      idx           <= '0;
      run_cnt       <= '0;
      rd_pend       <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum           <= '0;
`endif
    end else begin
      state    <= nxt;
      bus.done <= (nxt == IDLE) && (state != IDLE);
      rd_pend  <= bus.ren_ext_2;
      if (nxt != state)
        idx <= '0;
      else if (bus.wen_ext || bus.wen_ext_2 || out_hs)
        idx <= idx + 16'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
      if (bus.wen_ext || bus.wen_ext_2) sum <= sum + bus.in_data[31:0];
`endif
      case (state)
        IDLE: if (bus.start) begin
          bus.err <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum     <= '0;
`endif
        end
        HDR0: if (in_hs) begin
          imem_cnt <= bus.in_data[31:16];
          dmem_cnt <= bus.in_data[15:0];
          if (hdr_bad) bus.err <= 1'b1;
        end
        HDR1: if (in_hs) run_cnt <= bus.in_data[31:0];
`ifdef PROG_LOADER_CHECKSUM_EN
        CHK:  if (in_hs && bus.in_data[31:0] != sum) bus.err <= 1'b1;
`endif
        RUN:  run_cnt <= run_cnt - 32'd1;
        DUMP: begin
          if (rd_pend) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= bus.rdata_ext_2;
          end else if (out_hs) begin
            bus.out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench for prog_loader. Expected imem/dmem writes,
// dump reads and dump words are queued as stimulus is driven and popped by a
// negedge monitor as the DUT produces them.
module tb_prog_loader;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  prog_loader_if #(.DATA_W(32)) bus ();

  prog_loader dut (.clk(clk), .arst_n(arst_n), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  logic [63:0] exp_iw[$];
  logic [63:0] exp_dw[$];
  logic [31:0] exp_rd[$];
  logic [31:0] exp_out[$];
  logic [31:0] dmem [0:1023];
  logic [63:0] w_tmp;
  logic [31:0] prev_od;
  logic        prev_ov = 1'b0;
  logic        prev_hs = 1'b0;
  logic        exp_err = 1'b0;
  int          exp_run = 0;
  int          en_cnt = 0;
  int          done_cnt = 0;
  bit          toggle_rdy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // dmem model: read data valid the cycle after ren_ext_2
  always @(posedge clk) begin
    if (bus.wen_ext_2) dmem[bus.addr_ext_2[11:2]] <= bus.wdata_ext_2;
    if (bus.ren_ext_2) bus.rdata_ext_2 <= dmem[bus.addr_ext_2[11:2]];
  end

  // dump consumer ready: always 1, or toggling 1010 per cycle
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = toggle_rdy ? ~bus.out_ready : 1'b1;
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!arst_n) begin
      en_cnt  = 0;
      prev_ov = 1'b0;
      prev_hs = 1'b0;
    end else begin
      if (bus.cpu_enable) en_cnt++;
      if (bus.wen_ext || bus.wen_ext_2)
        chk("wr_excl", 32'(bus.wen_ext & bus.wen_ext_2), 0);
      if (bus.wen_ext) begin
        if (exp_iw.size() == 0) chk("unexp_iw", 1, 0);
        else begin
          w_tmp = exp_iw.pop_front();
          chk("iw_addr", bus.addr_ext, w_tmp[63:32]);
          chk("iw_data", bus.wdata_ext, w_tmp[31:0]);
        end
      end
      if (bus.wen_ext_2) begin
        if (exp_dw.size() == 0) chk("unexp_dw", 1, 0);
        else begin
          w_tmp = exp_dw.pop_front();
          chk("dw_addr", bus.addr_ext_2, w_tmp[63:32]);
          chk("dw_data", bus.wdata_ext_2, w_tmp[31:0]);
        end
      end
      if (bus.ren_ext_2) begin
        if (exp_rd.size() == 0) chk("unexp_rd", 1, 0);
        else chk("rd_addr", bus.addr_ext_2, exp_rd.pop_front());
      end
      if (prev_ov && !prev_hs) begin
        chk("ov_hold", 32'(bus.out_valid), 1);
        chk("od_hold", bus.out_data, prev_od);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_out.size() == 0) chk("unexp_out", 1, 0);
        else chk("out_data", bus.out_data, exp_out.pop_front());
      end
      prev_ov = bus.out_valid;
      prev_hs = bus.out_valid && bus.out_ready;
      prev_od = bus.out_data;
      if (bus.done) begin
        chk("run_len", en_cnt, exp_run);
        chk("err", 32'(bus.err), 32'(exp_err));
        en_cnt = 0;
        done_cnt++;
      end
    end
  end

  // called at posedge+1; returns at posedge+1 after the handshake edge
  task automatic send_word(input logic [31:0] w);
    bit got = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      got = bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!got) chk("in_timeout", 0, 1);
  endtask

  task automatic run_seq(input int ic, input int dc, input logic [31:0] run,
                         input int bubble, input bit tog, input bit bad_sum,
                         input logic [31:0] base);
    logic [31:0] words[$];
    logic [31:0] sum = 32'd0;
    bit hdr_bad;
    int snap, t;
    hdr_bad    = (ic > 512) || (dc > 1024);
    toggle_rdy = tog;
    exp_err    = hdr_bad || bad_sum;
    exp_run    = exp_err ? 0 : int'(run);
    if (!hdr_bad) begin
      for (int k = 0; k < ic + dc; k++) begin
        words.push_back(base + 32'(k));
        sum += base + 32'(k);
      end
      for (int k = 0; k < ic; k++) exp_iw.push_back({32'(k * 4), words[k]});
      for (int k = 0; k < dc; k++) begin
        exp_dw.push_back({32'(k * 4), words[ic + k]});
        if (!exp_err) begin
          exp_rd.push_back(32'(k * 4));
          exp_out.push_back(words[ic + k]);
        end
      end
    end
    snap = done_cnt;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("err_clr", 32'(bus.err), 0);
    chk("busy", 32'(bus.busy), 1);
    @(posedge clk); #1;
    send_word({ic[15:0], dc[15:0]});
    if (hdr_bad) begin
      for (t = 1; t <= 4; t++) begin
        @(negedge clk);
        if (bus.done) break;
      end
      chk("err_lat", 32'(t <= 2), 1);
    end else begin
      bus.start = 1'b1;  // must be ignored while busy
      send_word(run);
      bus.start = 1'b0;
      for (int k = 0; k < ic + dc; k++) begin
        if (k > 0) repeat (bubble) begin @(posedge clk); #1; end
        send_word(words[k]);
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      send_word(sum + 32'(bad_sum));
`endif
    end
    for (t = 0; t < 4000 && done_cnt == snap; t++) @(negedge clk);
    chk("done_cnt", done_cnt - snap, 1);
    chk("idle", 32'(bus.busy), 0);
    chk("iw_left", exp_iw.size(), 0);
    chk("dw_left", exp_dw.size(), 0);
    chk("rd_left", exp_rd.size(), 0);
    chk("out_left", exp_out.size(), 0);
    exp_iw.delete(); exp_dw.delete(); exp_rd.delete(); exp_out.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    bit seen;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 32'd0;
    #12;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_rdy", 32'(bus.in_ready), 0);
    chk("rst_en", 32'(bus.cpu_enable), 0);
    chk("rst_ov", 32'(bus.out_valid), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_wen", 32'(bus.wen_ext), 0);
    @(posedge clk); #1;
    arst_n = 1'b1;
    @(posedge clk); #1;

    run_seq(3, 0, 5, 0, 0, 0, 32'hA0);
    run_seq(600, 0, 7, 0, 0, 0, 32'd0);
    @(negedge clk);
    chk("err_sticky", 32'(bus.err), 1);
    @(posedge clk); #1;
    run_seq(0, 1025, 3, 0, 0, 0, 32'd0);
    run_seq(0, 4, 0, 0, 1, 0, 32'd1);
    run_seq(4, 2, 3, 2, 0, 0, $urandom);
    run_seq(0, 0, 0, 0, 0, 0, 32'd0);

    // reset during RUN cycle 2 of 10
    toggle_rdy = 1'b0;
    exp_iw.push_back({32'd0, 32'h55});
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    send_word({16'd1, 16'd0});
    send_word(32'd10);
    send_word(32'h55);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_word(32'h55);
`endif
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      seen = bus.cpu_enable;
    end
    chk("rst_run_seen", 32'(seen), 1);
    @(posedge clk); #1;
    arst_n = 1'b0;
    #1;
    chk("arst_en", 32'(bus.cpu_enable), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_rdy", 32'(bus.in_ready), 0);
    chk("arst_ren", 32'(bus.ren_ext_2), 0);
    chk("arst_done", 32'(bus.done), 0);
    chk("arst_iw_left", exp_iw.size(), 0);
    repeat (3) @(posedge clk);
    #1 arst_n = 1'b1;
    @(posedge clk); #1;

    run_seq(2, 3, 4, 0, 1, 0, $urandom);
    run_seq(512, 0, 1, 0, 0, 0, $urandom);
`ifdef PROG_LOADER_CHECKSUM_EN
    run_seq(2, 1, 3, 0, 0, 0, 32'd1);
    run_seq(2, 1, 3, 0, 0, 1, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot/test sequencer directly upstream of the cpu top; drives the cpu external memory ports and its enable input.
- Accepts a program image over a valid/ready word stream and writes it into instruction memory (addr_ext/wen_ext/wdata_ext) and data memory (addr_ext_2/wen_ext_2/wdata_ext_2).
- Raises enable for a programmed number of cycles, then reads data memory back through ren_ext_2/rdata_ext_2 and streams it out for checking.

Parameters:
- DATA_W, 32, stream and memory word width
- IMEM_DEPTH, 512, maximum instruction words accepted
- DMEM_DEPTH, 1024, maximum data words accepted/dumped
- ADDR_STEP, 4, byte-address increment per word

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse, begins a load/run/dump sequence when idle
- in_valid  in  1  input word valid
- in_ready  out  1  loader accepts in_data this cycle
- in_data  in  32  header/image word
- addr_ext  out  32  imem byte address
- wen_ext  out  1  imem write enable
- wdata_ext  out  32  imem write data
- addr_ext_2  out  32  dmem byte address
- wen_ext_2  out  1  dmem write enable
- ren_ext_2  out  1  dmem read enable
- wdata_ext_2  out  32  dmem write data
- rdata_ext_2  in  32  dmem read data, valid the cycle after ren_ext_2
- cpu_enable  out  1  cpu enable
- out_valid  out  1  dump word valid
- out_ready  in  1  dump consumer ready
- out_data  out  32  dumped dmem word
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on entering IDLE after a sequence
- err  out  1  sticky until next start: header count exceeded depth

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-sequence aborts immediately; cpu_enable drops asynchronously; no partial writes are completed.
- Handshake: a transfer occurs when in_valid && in_ready. in_ready is high only in HDR0, HDR1, LD_IMEM and LD_DMEM. The same rule applies to out_valid/out_ready.
- IDLE: start -> HDR0, clears err. start while busy is ignored.
- HDR0: accept word {imem_cnt[31:16], dmem_cnt[15:0]}.
  - imem_cnt > IMEM_DEPTH or dmem_cnt > DMEM_DEPTH -> err=1, done pulse, IDLE.
  - Otherwise -> HDR1.
- HDR1: accept run_cycles[31:0].
  - Next state is LD_IMEM if imem_cnt != 0, else LD_DMEM if dmem_cnt != 0, else RUN.
- LD_IMEM: each accepted word drives wen_ext=1, addr_ext=idx*ADDR_STEP, wdata_ext=in_data in the same cycle (combinational from the handshake). idx starts at 0. After word imem_cnt-1, go to LD_DMEM, or to RUN if dmem_cnt == 0.
- LD_DMEM: same rules on the _2 ports; after the last word -> RUN.
- RUN: cpu_enable=1 for exactly run_cycles cycles, counted down.
  - run_cycles == 0 skips RUN with no enable cycle.
  - Then -> DUMP if dmem_cnt != 0, else IDLE with done.
- DUMP: reads dmem_cnt words from address 0 upward.
  - Issue ren_ext_2=1 with addr_ext_2; the next cycle, capture rdata_ext_2 into a holding register and raise out_valid.
  - Hold out_data stable until out_ready. Issue the next read only after the handshake, so at most one word is outstanding.
  - After the last handshake -> IDLE, done pulse.
- Write enables and ren_ext_2 are never high outside their states. cpu_enable is never high outside RUN.
- The loader never drives imem and dmem writes in the same cycle.
- Addresses are 32-bit: idx zero-extended and multiplied by ADDR_STEP; no wrap occurs within the depth limits.

Optional Feature:
- PROG_LOADER_CHECKSUM_EN. When defined:
  - An extra stream word follows the last dmem word, or follows HDR1 when both counts are 0.
  - It is compared with the 32-bit modulo-2^32 sum of all imem+dmem words loaded.
  - On mismatch: err=1, skip RUN/DUMP, done pulse, IDLE.
- When undefined: no trailer word is consumed; checksum logic is absent.

Test Plan:
- Load imem_cnt=3 words {A,B,C}, dmem_cnt=0, run_cycles=5 -> wen_ext at addr 0,4,8 with A,B,C; cpu_enable high exactly 5 cycles; done; no out_valid.
- Header imem_cnt=600 (>512) -> err=1, no wen_ext/wen_ext_2, done within 2 cycles, back to IDLE.
- dmem_cnt=4 {1,2,3,4}, run_cycles=0, out_ready toggling 1010 -> out_data 1,2,3,4 in order, each held stable while out_ready low; ren_ext_2 at addr 0,4,8,12.
- in_valid bubbles during LD_IMEM (valid every 3rd cycle) -> writes only on handshake cycles, addresses contiguous.
- arst_n low during RUN cycle 2 of 10 -> cpu_enable 0 immediately, all outputs 0; after release, a new start runs a full sequence correctly.
- With PROG_LOADER_CHECKSUM_EN: imem {1,2}, dmem {3}, trailer 6 -> RUN proceeds; trailer 7 -> err=1, no cpu_enable.
